// File: rtl/integ_pkg.sv
// integ_pkg: shared definitions for the integration stream feeder.
//   INIT_ADDR / DATA_ADDR : register-file word addresses targeted by the feeder
//   feeder_state_t        : feeder job FSM encoding
package integ_pkg;

    localparam logic [7:0] INIT_ADDR = 8'd0;
    localparam logic [7:0] DATA_ADDR = 8'd1;

    typedef enum logic [1:0] {
        StIdle,
        StWrInit,
        StStream,
        StFinish
    } feeder_state_t;

endpackage

// File: rtl/integ_stream_feeder_if.sv
// integ_stream_feeder_if: sample stream sink plus Avalon-MM write master bus.
//   snk_valid/snk_data/snk_ready : valid/ready sample stream into the feeder
//   avm_m0_address/write/writedata/waitrequest : Avalon-MM write master
//   modport master : feeder side (consumes the stream, drives the bus)
//   modport slave  : environment side (produces the stream, answers the bus)
interface integ_stream_feeder_if #(
    parameter int unsigned N = 32
) ();

    logic         snk_valid;
    logic [N-1:0] snk_data;
    logic         snk_ready;
    logic [7:0]   avm_m0_address;
    logic         avm_m0_write;
    logic [N-1:0] avm_m0_writedata;
    logic         avm_m0_waitrequest;

    modport master (
        input  snk_valid,
        input  snk_data,
        output snk_ready,
        output avm_m0_address,
        output avm_m0_write,
        output avm_m0_writedata,
        input  avm_m0_waitrequest
    );

    modport slave (
        output snk_valid,
        output snk_data,
        input  snk_ready,
        input  avm_m0_address,
        input  avm_m0_write,
        input  avm_m0_writedata,
        output avm_m0_waitrequest
    );

endinterface

// File: rtl/integ_stream_feeder_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
//   clk, srst : clock and synchronous active-high reset (flushes contents)
//   push/wdata: write request and data; ignored when full
//   pop       : read request; ignored when empty
//   rdata     : head entry, valid whenever empty=0
//   full/empty: derived from the registered occupancy count
module sync_fifo #(
    parameter int unsigned N          = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         push,
    input  logic [N-1:0] wdata,
    input  logic         pop,
    output logic [N-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    logic [N-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/integ_stream_feeder.sv
// integ_stream_feeder: buffers a sample stream and, per job, writes one init word
// to INIT_ADDR followed by sample_count samples to DATA_ADDR over Avalon-MM.
//   clk, srst    : clock and synchronous active-high reset (aborts any job)
//   start        : one-cycle job request, ignored while busy
//   init_value   : init word, latched when start is accepted
//   sample_count : samples in the job, latched when start is accepted
//   bus          : stream sink + Avalon-MM write master (master modport)
//   busy         : job in progress
//   done         : one-cycle pulse when a job completes
module integ_stream_feeder
    import integ_pkg::*;
#(
    parameter int unsigned N          = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  start,
    input  logic [N-1:0]          init_value,
    input  logic [CNT_W-1:0]      sample_count,
    integ_stream_feeder_if.master bus,
    output logic                  busy,
    output logic                  done
);

    feeder_state_t    state_q, state_d;
    logic             write_q, write_d;
    logic [7:0]       addr_q, addr_d;
    logic [N-1:0]     wdata_q, wdata_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;

    logic             pop;
    logic [N-1:0]     fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             wr_done;
    logic             last_write;

    sync_fifo #(
        .N          (N),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .srst  (srst),
        .push  (bus.snk_valid),
        .wdata (bus.snk_data),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.snk_ready        = !fifo_full;
    assign bus.avm_m0_address   = addr_q;
    assign bus.avm_m0_write     = write_q;
    assign bus.avm_m0_writedata = wdata_q;

    assign wr_done = write_q && !bus.avm_m0_waitrequest;
    // remaining_q counts samples not yet written; in WR_INIT no sample has been sent.
    assign last_write = (state_q == StWrInit) ? (remaining_q == '0)
                                              : (remaining_q == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (srst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StWrInit;
            StWrInit: if (wr_done) state_d = last_write ? StFinish : StStream;
            StStream: if (wr_done && last_write) state_d = StFinish;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        remaining_d = remaining_q;
        pop         = 1'b0;
        busy        = (state_q != StIdle);
        done        = (state_q == StFinish);
        case (state_q)
            StIdle: begin
                if (start) begin
                    write_d     = 1'b1;
                    addr_d      = INIT_ADDR;
                    wdata_d     = init_value;
                    remaining_d = sample_count;
                end
            end
            StWrInit, StStream: begin
                if (wr_done && state_q == StStream) remaining_d = remaining_q - CNT_W'(1);
                if (wr_done && last_write) begin
                    write_d = 1'b0;
                end else if (!write_q || wr_done) begin
                    // Bus is free (or frees at this edge): load the next sample if any.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        write_d = 1'b1;
                        addr_d  = DATA_ADDR;
                        wdata_d = fifo_head;
                    end else begin
                        write_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            remaining_q <= '0;
        end else begin
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            remaining_q <= remaining_d;
        end
    end

endmodule

// File: tb/tb_integ_stream_feeder.sv
// tb_integ_stream_feeder: directed and randomized stimulus for integ_stream_feeder,
// checked against a job-level reference model of the expected write sequence.
module tb_integ_stream_feeder;
    import integ_pkg::*;

    localparam int unsigned N     = 32;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             srst;
    logic             start;
    logic [N-1:0]     init_value;
    logic [CNT_W-1:0] sample_count;
    logic             busy;
    logic             done;

    integ_stream_feeder_if #(.N(N)) bus ();

    integ_stream_feeder #(
        .N          (N),
        .FIFO_DEPTH (8),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .srst         (srst),
        .start        (start),
        .init_value   (init_value),
        .sample_count (sample_count),
        .bus          (bus),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: samples accepted but not yet written, and the current job.
    logic [N-1:0] sq[$];
    bit           job_on     = 1'b0;
    int           job_k      = 0;
    int           job_cnt    = 0;
    int           wr_idx     = 0;
    int           done_cyc   = -1;
    logic [N-1:0] job_init   = '0;
    bit           prev_stall = 1'b0;
    logic [7:0]   prev_addr  = '0;
    logic [N-1:0] prev_data  = '0;

    always @(negedge clk) begin
        int           sz0;
        logic [7:0]   exp_addr;
        logic [N-1:0] exp_data;
        sz0 = sq.size();
        if (srst) begin
            job_on     = 1'b0;
            done_cyc   = -1;
            prev_stall = 1'b0;
            sq.delete();
        end else begin
            if (prev_stall) begin
                check("hold_write", 64'(bus.avm_m0_write), 64'(1));
                check("hold_addr", 64'(bus.avm_m0_address), 64'(prev_addr));
                check("hold_data", 64'(bus.avm_m0_writedata), 64'(prev_data));
            end
            check("busy", 64'(busy), 64'(job_on && cyc > job_k));
            check("done", 64'(done), 64'(job_on && cyc == done_cyc));
            // The DUT never holds more than the model, so free model space implies ready.
            if (sz0 < 8)     check("snk_ready", 64'(bus.snk_ready), 64'(1));
            else if (!job_on) check("snk_ready_full", 64'(bus.snk_ready), 64'(0));
            if (job_on && wr_idx == 0 && cyc == job_k + 1)
                check("first_write", 64'(bus.avm_m0_write), 64'(1));
            if (bus.avm_m0_write) begin
                check("write_in_job", 64'(job_on && cyc > job_k && wr_idx <= job_cnt), 64'(1));
                if (job_on && !bus.avm_m0_waitrequest) begin
                    if (wr_idx == 0) begin
                        exp_addr = INIT_ADDR;
                        exp_data = job_init;
                    end else begin
                        exp_addr = DATA_ADDR;
                        exp_data = (sq.size() > 0) ? sq.pop_front() : 'x;
                    end
                    check("wr_addr", 64'(bus.avm_m0_address), 64'(exp_addr));
                    check("wr_data", 64'(bus.avm_m0_writedata), 64'(exp_data));
                    wr_idx++;
                    if (wr_idx == job_cnt + 1) done_cyc = cyc + 1;
                end
            end
            prev_stall = bus.avm_m0_write && bus.avm_m0_waitrequest;
            prev_addr  = bus.avm_m0_address;
            prev_data  = bus.avm_m0_writedata;
            if (bus.snk_valid && sz0 < 8) sq.push_back(bus.snk_data);
            if (start && !job_on) begin
                job_on   = 1'b1;
                job_k    = cyc;
                job_cnt  = int'(sample_count);
                job_init = init_value;
                wr_idx   = 0;
                done_cyc = -1;
            end else if (job_on && cyc == done_cyc) begin
                job_on = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [N-1:0] v);
        bus.snk_valid = 1'b1;
        bus.snk_data  = v;
        tick();
        bus.snk_valid = 1'b0;
    endtask

    task automatic start_job(input logic [N-1:0] iv, input logic [CNT_W-1:0] cnt, output int k);
        start        = 1'b1;
        init_value   = iv;
        sample_count = cnt;
        k            = cyc;
        tick();
        start        = 1'b0;
        init_value   = $urandom;
        sample_count = CNT_W'($urandom);
    endtask

    task automatic wait_done(input int budget, output int dc);
        dc = -1;
        for (int c = 0; c < budget && dc < 0; c++) begin
            @(negedge clk);
            if (done) dc = cyc;
            tick();
        end
        check("done_seen", 64'(dc >= 0), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int dc;
        int p;
        bit got;

        srst                   = 1'b1;
        start                  = 1'b0;
        init_value             = '0;
        sample_count           = '0;
        bus.snk_valid          = 1'b0;
        bus.snk_data           = '0;
        bus.avm_m0_waitrequest = 1'b0;
        repeat (3) tick();
        srst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_write", 64'(bus.avm_m0_write), 64'(0));
        check("rst_addr", 64'(bus.avm_m0_address), 64'(0));
        check("rst_data", 64'(bus.avm_m0_writedata), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_ready", 64'(bus.snk_ready), 64'(1));
        tick();

        // Basic job, pre-filled FIFO
        push(3); push(5); push(7);
        start_job(55, 3, k);
        wait_done(50, dc);
        check("basic_done_cycle", 64'(dc), 64'(k + 5));

        // Four-cycle stall on the second write
        push(3); push(5); push(7);
        start_job(56, 3, k);
        tick();
        bus.avm_m0_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_addr", 64'(bus.avm_m0_address), 64'(DATA_ADDR));
            check("stall_data", 64'(bus.avm_m0_writedata), 64'(3));
            tick();
        end
        bus.avm_m0_waitrequest = 1'b0;
        wait_done(50, dc);
        check("stall_done_cycle", 64'(dc), 64'(k + 9));

        // Starved FIFO
        start_job(9, 2, k);
        tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("starved_idle", 64'(bus.avm_m0_write), 64'(0));
            tick();
        end
        p = cyc;
        bus.snk_valid = 1'b1;
        bus.snk_data  = 22;
        tick();
        bus.snk_valid = 1'b0;
        @(negedge clk);
        check("push_lat1_write", 64'(bus.avm_m0_write), 64'(0));
        tick();
        @(negedge clk);
        check("push_lat2_cycle", 64'(cyc), 64'(p + 2));
        check("push_lat2_write", 64'(bus.avm_m0_write), 64'(1));
        check("push_lat2_data", 64'(bus.avm_m0_writedata), 64'(22));
        tick();
        push(23);
        wait_done(50, dc);

        // Full FIFO in IDLE, ninth sample refused
        for (int i = 0; i < 8; i++) begin
            bus.snk_valid = 1'b1;
            bus.snk_data  = $urandom;
            @(negedge clk);
            check("fill_ready", 64'(bus.snk_ready), 64'(1));
            tick();
        end
        bus.snk_data = 32'hDEAD_BEEF;
        repeat (2) begin
            @(negedge clk);
            check("full_ready", 64'(bus.snk_ready), 64'(0));
            tick();
        end
        bus.snk_valid = 1'b0;
        start_job($urandom, 8, k);
        @(negedge clk);
        check("full_ready_init", 64'(bus.snk_ready), 64'(0));
        tick();
        @(negedge clk);
        check("ready_after_pop", 64'(bus.snk_ready), 64'(1));
        tick();
        wait_done(50, dc);
        check("full_done_cycle", 64'(dc), 64'(k + 10));

        // Zero-count job
        start_job(77, 0, k);
        wait_done(20, dc);
        check("zero_done_cycle", 64'(dc), 64'(k + 2));

        // Start while busy and start in the done cycle are both ignored
        push(41); push(42); push(43); push(44);
        start_job(88, 4, k);
        tick();
        start        = 1'b1;
        init_value   = 99;
        sample_count = 7;
        tick();
        start = 1'b0;
        repeat (k + 6 - cyc) tick();
        start        = 1'b1;
        init_value   = 11;
        sample_count = 1;
        @(negedge clk);
        check("busy_start_done", 64'(done), 64'(1));
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("ignored_start_write", 64'(bus.avm_m0_write), 64'(0));
            tick();
        end

        // Reset mid-job
        push(61); push(62); push(63); push(64); push(65);
        start_job(123, 5, k);
        tick();
        tick();
        srst                   = 1'b1;
        bus.avm_m0_waitrequest = 1'b1;
        tick();
        srst                   = 1'b0;
        bus.avm_m0_waitrequest = 1'b0;
        @(negedge clk);
        check("abort_write", 64'(bus.avm_m0_write), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_ready", 64'(bus.snk_ready), 64'(1));
        check("abort_done", 64'(done), 64'(0));
        tick();
        repeat (8) tick();
        push(71); push(72);
        start_job(124, 2, k);
        wait_done(50, dc);
        check("after_abort_done_cycle", 64'(dc), 64'(k + 4));

        // Randomized jobs with random stalls and stream gaps
        for (int j = 0; j < 8; j++) begin
            start_job($urandom, CNT_W'($urandom_range(0, 12)), k);
            got = 1'b0;
            for (int c = 0; c < 500 && !got; c++) begin
                bus.avm_m0_waitrequest = ($urandom_range(0, 2) == 0);
                bus.snk_valid          = (sq.size() < 8) && ($urandom_range(0, 1) == 1);
                bus.snk_data           = $urandom;
                @(negedge clk);
                if (done) got = 1'b1;
                tick();
            end
            check("rand_done_seen", 64'(got), 64'(1));
            bus.snk_valid          = 1'b0;
            bus.avm_m0_waitrequest = 1'b0;
        end

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
